id_pipe_stage: RTL and testbench

//  Parametrised decode-stage pipeline register for the MIPS pipeline, between IF and EX.

---
 rtl/id_pipe_stage.sv | 116 +++++++++++
 tb/tb_id_pipe_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// Decode-stage pipeline register between IF and EX: field split, immediate extension,
// load-use hazard bubbles, valid/ready handshake, flush. Optional macro: WB_BYPASS_EN.
module id_pipe_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned RAW  = 5,
    parameter int unsigned IMMW = 16,
    parameter int unsigned CNTW = 16
) (
    input  logic            clkd,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   pc_in,
    input  logic [31:0]     instr_in,
    output logic [RAW-1:0]  rs_addr,
    output logic [RAW-1:0]  rt_addr,
    input  logic [DW-1:0]   rs_data,
    input  logic [DW-1:0]   rt_data,
    input  logic            ext_sign,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            ex_memread,
    input  logic [RAW-1:0]  ex_rt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   pc_out,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [DW-1:0]   imm_out,
    output logic [RAW-1:0]  rs_out,
    output logic [RAW-1:0]  rt_out,
    output logic [RAW-1:0]  rd_out,
    output logic [5:0]      func_out,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int unsigned EXTW = DW - IMMW;

    logic            hazard;
    logic            load;
    logic [RAW-1:0]  rd_addr;
    logic [DW-1:0]   imm_ext;
    logic [DW-1:0]   a_next;
    logic [DW-1:0]   b_next;

    // Register-file addresses go out straight from the incoming word.
    assign rs_addr = RAW'(instr_in[25:21]);
    assign rt_addr = RAW'(instr_in[20:16]);
    assign rd_addr = RAW'(instr_in[15:11]);

    // Load-use hazard: the load in EX writes a register this instruction reads; r0 exempt.
    assign hazard = in_valid & ex_memread & (ex_rt != '0) &
                    ((ex_rt == rs_addr) | (ex_rt == rt_addr));

    assign in_ready = !rst & !flush & !hazard & (!out_valid | out_ready);
    assign load     = in_valid & in_ready;

    assign imm_ext = ext_sign ? {{EXTW{instr_in[IMMW-1]}}, instr_in[IMMW-1:0]}
                              : {{EXTW{1'b0}}, instr_in[IMMW-1:0]};

`ifdef WB_BYPASS_EN
    // Writeback-to-decode bypass so a same-cycle write is seen without a register-file fix.
    always_comb begin
        a_next = rs_data;
        b_next = rt_data;
        if (wb_we && (wb_addr != '0) && (wb_addr == rs_addr)) a_next = wb_data;
        if (wb_we && (wb_addr != '0) && (wb_addr == rt_addr)) b_next = wb_data;
    end
`else
    always_comb begin
        a_next = rs_data;
        b_next = rt_data;
    end
`endif

    // Output register: flush beats load, load beats drain; otherwise hold.
    always_ff @(posedge clkd) begin
        if (rst) begin
            out_valid <= 1'b0;
            pc_out    <= '0;
            a_out     <= '0;
            b_out     <= '0;
            imm_out   <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
            func_out  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            pc_out    <= pc_in;
            a_out     <= a_next;
            b_out     <= b_next;
            imm_out   <= imm_ext;
            rs_out    <= rs_addr;
            rt_out    <= rt_addr;
            rd_out    <= rd_addr;
            func_out  <= instr_in[5:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of hazard-stall cycles; a flushed cycle is not a stall.
    always_ff @(posedge clkd) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage; CNTW reduced to 4 so saturation is reached quickly.
module tb_id_pipe_stage;

    localparam int unsigned DW   = 32;
    localparam int unsigned RAW  = 5;
    localparam int unsigned IMMW = 16;
    localparam int unsigned CNTW = 4;

    logic            clkd;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   pc_in;
    logic [31:0]     instr_in;
    logic [RAW-1:0]  rs_addr;
    logic [RAW-1:0]  rt_addr;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic            ext_sign;
    logic            wb_we;
    logic [RAW-1:0]  wb_addr;
    logic [DW-1:0]   wb_data;
    logic            ex_memread;
    logic [RAW-1:0]  ex_rt;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   pc_out;
    logic [DW-1:0]   a_out;
    logic [DW-1:0]   b_out;
    logic [DW-1:0]   imm_out;
    logic [RAW-1:0]  rs_out;
    logic [RAW-1:0]  rt_out;
    logic [RAW-1:0]  rd_out;
    logic [5:0]      func_out;
    logic [CNTW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    id_pipe_stage #(.DW(DW), .RAW(RAW), .IMMW(IMMW), .CNTW(CNTW)) dut (
        .clkd(clkd), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .ext_sign(ext_sign),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .a_out(a_out), .b_out(b_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .func_out(func_out), .stall_cnt(stall_cnt)
    );

    initial begin
        clkd = 1'b0;
        forever #5 clkd = ~clkd;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before checking or driving.
    task automatic step();
        @(posedge clkd);
        #1;
    endtask

    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;

    initial begin
        rst = 1'b1; in_valid = 1'b0; pc_in = '0; instr_in = '0;
        rs_data = '0; rt_data = '0; ext_sign = 1'b1;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_memread = 1'b0; ex_rt = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset
        step(); step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc",    64'(pc_out),    64'd0);
        chk("rst_a",     64'(a_out),     64'd0);
        chk("rst_imm",   64'(imm_out),   64'd0);
        chk("rst_func",  64'(func_out),  64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_ready", 64'(in_ready),  64'd0);

        // First load: lw r3, 16(r2)
        rst = 1'b0;
        in_valid = 1'b1; instr_in = 32'h8C43_0010; pc_in = 32'h0000_0100;
        rs_data = 32'h0000_AAAA; rt_data = 32'h0000_BBBB;
        #1;
        chk("rs_addr",  64'(rs_addr),  64'd2);
        chk("rt_addr",  64'(rt_addr),  64'd3);
        chk("rdy_idle", 64'(in_ready), 64'd1);
        step();
        chk("ld_valid", 64'(out_valid), 64'd1);
        chk("ld_rs",    64'(rs_out),    64'd2);
        chk("ld_rt",    64'(rt_out),    64'd3);
        chk("ld_rd",    64'(rd_out),    64'd0);
        chk("ld_imm",   64'(imm_out),   64'h0000_0010);
        chk("ld_pc",    64'(pc_out),    64'h0000_0100);
        chk("ld_a",     64'(a_out),     64'h0000_AAAA);
        chk("ld_b",     64'(b_out),     64'h0000_BBBB);
        chk("ld_func",  64'(func_out),  64'h10);

        // Immediate extension
        instr_in = 32'h2041_8000; ext_sign = 1'b1;
        step();
        chk("imm_sext", 64'(imm_out), 64'hFFFF_8000);
        ext_sign = 1'b0;
        step();
        chk("imm_zext", 64'(imm_out), 64'h0000_8000);

        // r0 as load destination never hazards
        ex_memread = 1'b1; ex_rt = 5'd0; instr_in = 32'h0003_1020;
        #1;
        chk("r0_nohaz", 64'(in_ready), 64'd1);

        // Load-use hazard on rs=3: bubble, data held
        ex_rt = 5'd3; instr_in = 32'h0064_3020; pc_in = 32'h0000_0200;
        #1;
        chk("haz_ready", 64'(in_ready), 64'd0);
        step();
        chk("haz_valid", 64'(out_valid), 64'd0);
        chk("haz_stall", 64'(stall_cnt), 64'd1);
        chk("haz_imm",   64'(imm_out),   64'h0000_8000);
        ex_memread = 1'b0;
        #1;
        chk("unhaz_rdy", 64'(in_ready), 64'd1);
        step();
        chk("acc_valid", 64'(out_valid), 64'd1);
        chk("acc_rs",    64'(rs_out),    64'd3);
        chk("acc_rd",    64'(rd_out),    64'd6);
        chk("acc_func",  64'(func_out),  64'h20);
        chk("acc_pc",    64'(pc_out),    64'h0000_0200);

        // Backpressure hold for 3 cycles
        out_ready = 1'b0; instr_in = 32'h8C45_0020; pc_in = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_rdy", 64'(in_ready), 64'd0);
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_rs",    64'(rs_out),    64'd3);
            chk("hold_pc",    64'(pc_out),    64'h0000_0200);
        end

        // Flush discards held and incoming
        flush = 1'b1;
        #1;
        chk("fl_rdy", 64'(in_ready), 64'd0);
        step();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_rs",    64'(rs_out),    64'd3);
        chk("fl_pc",    64'(pc_out),    64'h0000_0200);

        // Flush together with hazard is not a stall
        ex_memread = 1'b1; ex_rt = 5'd5;
        step();
        chk("flhaz_stall", 64'(stall_cnt), 64'd1);
        chk("flhaz_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; ex_memread = 1'b0; out_ready = 1'b1;

        // Writeback bypass on rs=2
        instr_in = 32'h8C43_0010; rs_data = '0; rt_data = 32'h0000_0055;
        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_1234;
`ifdef WB_BYPASS_EN
        exp_a = 32'h0000_1234;
`else
        exp_a = 32'h0000_0000;
`endif
        step();
        chk("byp_a", 64'(a_out), 64'(exp_a));
        chk("byp_b", 64'(b_out), 64'h0000_0055);

        // Bypass on rt=3
        wb_addr = 5'd3;
`ifdef WB_BYPASS_EN
        exp_b = 32'h0000_1234;
`else
        exp_b = 32'h0000_0055;
`endif
        step();
        chk("bypb_a", 64'(a_out), 64'h0000_0000);
        chk("bypb_b", 64'(b_out), 64'(exp_b));

        // wb_addr=0 never bypasses
        wb_addr = 5'd0; instr_in = 32'h0003_1020; rs_data = 32'h0000_0077;
        step();
        chk("byp0_a",  64'(a_out),  64'h0000_0077);
        chk("byp0_rd", 64'(rd_out), 64'd2);
        wb_we = 1'b0;

        // Long hazard saturates the counter
        ex_memread = 1'b1; ex_rt = 5'd3; instr_in = 32'h0064_3020;
        for (int i = 0; i < 5; i++) step();
        chk("sat_mid", 64'(stall_cnt), 64'd6);
        for (int i = 0; i < (1 << CNTW); i++) step();
        chk("sat_full",  64'(stall_cnt), 64'hF);
        chk("sat_valid", 64'(out_valid), 64'd0);

        // Reset mid-stall
        rst = 1'b1;
        step();
        chk("rst2_stall", 64'(stall_cnt), 64'd0);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_rs",    64'(rs_out),    64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
